// File: rtl/bn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bn_pkg
// Purpose : Shared word format, saturation limits, rounding constant and the
//           round/bias/saturate/ReLU helper used by batch-norm stages.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bn_pkg;

    // Word format: signed Q(c_bn_d_wl-c_bn_fl).c_bn_fl
    localparam int c_bn_d_wl = 24;
    localparam int c_bn_fl   = 16;
    localparam int c_bn_p_wl = 2 * c_bn_d_wl;   // full product width

    localparam logic signed [c_bn_d_wl-1:0] c_sat_max = {1'b0, {(c_bn_d_wl-1){1'b1}}};
    localparam logic signed [c_bn_d_wl-1:0] c_sat_min = {1'b1, {(c_bn_d_wl-1){1'b0}}};

    // 2^(FL-1) at product width + 1, so adding it can never overflow
    localparam logic signed [c_bn_p_wl:0] c_round_half =
        {{(c_bn_p_wl+1-c_bn_fl){1'b0}}, 1'b1, {(c_bn_fl-1){1'b0}}};

    // Round the Q.2FL product half-up to Q.FL, add the bias, saturate to the
    // output word and optionally clamp negatives to zero. All intermediate
    // arithmetic is carried at c_bn_p_wl+1 bits so nothing is truncated
    // before the saturation compare.
    function automatic logic signed [c_bn_d_wl-1:0] sat_round(
        input logic signed [c_bn_p_wl-1:0] p,
        input logic signed [c_bn_d_wl-1:0] b,
        input logic                        relu
    );
        logic signed [c_bn_p_wl:0]   w_r;
        logic signed [c_bn_p_wl:0]   w_s;
        logic signed [c_bn_p_wl:0]   w_max;
        logic signed [c_bn_p_wl:0]   w_min;
        logic signed [c_bn_d_wl-1:0] w_res;
        w_max = (c_bn_p_wl+1)'(c_sat_max);
        w_min = (c_bn_p_wl+1)'(c_sat_min);
        w_r   = ($signed({p[c_bn_p_wl-1], p}) + c_round_half) >>> c_bn_fl;
        w_s   = w_r + (c_bn_p_wl+1)'(b);
        if (w_s > w_max) begin
            w_res = c_sat_max;
        end else if (w_s < w_min) begin
            w_res = c_sat_min;
        end else begin
            w_res = w_s[c_bn_d_wl-1:0];
        end
        if (relu && w_res[c_bn_d_wl-1]) begin
            w_res = '0;
        end
        return w_res;
    endfunction

endpackage : bn_pkg
`default_nettype wire

// File: rtl/bn_coef_bank.sv
`default_nettype none
// ============================================================================
// Module  : bn_coef_bank
// Purpose : CH-entry register file of per-channel scale (A) and bias (B).
//           One synchronous write port, one combinational read port.
//           Reset loads the identity transform (A = 1.0, B = 0).
// Ports   : clk, rst           - clock, synchronous active-high reset
//           i_we/i_waddr       - write strobe and channel (>= CH ignored)
//           i_a/i_b            - values written
//           i_raddr            - read channel
//           o_a/o_b            - coefficients of i_raddr (pre-write values)
// Revision: 1.0 - initial release
// ============================================================================
module bn_coef_bank #(
    parameter int D_WL = 24,
    parameter int FL   = 16,
    parameter int CH   = 16,
    parameter int CW   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [CW-1:0]          i_waddr,
    input  logic signed [D_WL-1:0] i_a,
    input  logic signed [D_WL-1:0] i_b,
    input  logic [CW-1:0]          i_raddr,
    output logic signed [D_WL-1:0] o_a,
    output logic signed [D_WL-1:0] o_b
);

    localparam logic signed [D_WL-1:0] c_a_one = D_WL'(1) << FL;

    logic signed [D_WL-1:0] r_a [CH];
    logic signed [D_WL-1:0] r_b [CH];

    // Address decode by explicit compare: out-of-range addresses match no
    // entry and the write is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_a[i] <= c_a_one;
                r_b[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < CH; i++) begin
                if (i_waddr == CW'(i)) begin
                    r_a[i] <= i_a;
                    r_b[i] <= i_b;
                end
            end
        end
    end

    assign o_a = r_a[i_raddr];
    assign o_b = r_b[i_raddr];

endmodule : bn_coef_bank
`default_nettype wire

// File: rtl/bn_multi.sv
`default_nettype none
// ============================================================================
// Module  : bn_multi
// Purpose : Multi-channel batch-norm affine stage,
//           D_O = sat(round(D_IN * A[ch]) + B[ch]) with optional ReLU.
//           3-stage pipeline, valid/ready backpressure, auto-wrapping
//           channel counter resynchronised by i_first.
// Ports   : CLK, rst            - clock, synchronous active-high reset
//           relu_en             - clamp negative results to zero (at S3)
//           coef_we/coef_addr/coef_a/coef_b - coefficient write port
//           i_valid/i_first/D_IN/i_ready    - input stream
//           o_valid/o_ready/D_O/o_chan      - output stream
// Revision: 1.0 - initial release
// ============================================================================
module bn_multi
    import bn_pkg::*;
#(
    parameter int D_WL = c_bn_d_wl,
    parameter int FL   = c_bn_fl,
    parameter int CH   = 16,
    parameter int CW   = $clog2(CH)
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   relu_en,
    input  logic                   coef_we,
    input  logic [CW-1:0]          coef_addr,
    input  logic signed [D_WL-1:0] coef_a,
    input  logic signed [D_WL-1:0] coef_b,
    input  logic                   i_valid,
    input  logic                   i_first,
    input  logic signed [D_WL-1:0] D_IN,
    output logic                   i_ready,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic signed [D_WL-1:0] D_O,
    output logic [CW-1:0]          o_chan
);

    // ------------------------------------------------------------------
    // Handshake: a held output freezes the whole pipe and the counter
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_accept;

    assign w_stall  = o_valid & ~o_ready;
    assign i_ready  = ~w_stall;
    assign w_accept = i_valid & ~w_stall;

    // ------------------------------------------------------------------
    // Channel counter
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_ch;

    assign w_ch = i_first ? '0 : r_cnt;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (w_ch == CW'(CH-1)) ? '0 : w_ch + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Coefficient bank. The read is combinational off the current
    // channel, so S1 captures the value held before a same-cycle write.
    // ------------------------------------------------------------------
    logic signed [D_WL-1:0] w_a;
    logic signed [D_WL-1:0] w_b;

    bn_coef_bank #(
        .D_WL (D_WL),
        .FL   (FL),
        .CH   (CH),
        .CW   (CW)
    ) u_bank (
        .clk     (CLK),
        .rst     (rst),
        .i_we    (coef_we),
        .i_waddr (coef_addr),
        .i_a     (coef_a),
        .i_b     (coef_b),
        .i_raddr (w_ch),
        .o_a     (w_a),
        .o_b     (w_b)
    );

    // ------------------------------------------------------------------
    // Pipeline valids (the only pipeline state that needs reset)
    // ------------------------------------------------------------------
    logic r_s1_v;
    logic r_s2_v;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            o_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_v  <= i_valid;
            r_s2_v  <= r_s1_v;
            o_valid <= r_s2_v;
        end
    end

    // ------------------------------------------------------------------
    // S1: capture sample, channel and its coefficients
    // S2: full-width signed product
    // ------------------------------------------------------------------
    logic signed [D_WL-1:0]   r_s1_d;
    logic signed [D_WL-1:0]   r_s1_a;
    logic signed [D_WL-1:0]   r_s1_b;
    logic [CW-1:0]            r_s1_ch;
    logic signed [2*D_WL-1:0] r_s2_p;
    logic signed [D_WL-1:0]   r_s2_b;
    logic [CW-1:0]            r_s2_ch;
    logic signed [2*D_WL-1:0] w_prod;

    assign w_prod = (2*D_WL)'(r_s1_d) * (2*D_WL)'(r_s1_a);

    always_ff @(posedge CLK) begin
        if (!w_stall) begin
            r_s1_d  <= D_IN;
            r_s1_a  <= w_a;
            r_s1_b  <= w_b;
            r_s1_ch <= w_ch;
            r_s2_p  <= w_prod;
            r_s2_b  <= r_s1_b;
            r_s2_ch <= r_s1_ch;
        end
    end

    // ------------------------------------------------------------------
    // S3: round, add bias, saturate, ReLU
    // ------------------------------------------------------------------
    logic signed [D_WL-1:0] w_s3;

    assign w_s3 = sat_round(r_s2_p, r_s2_b, relu_en);

    always_ff @(posedge CLK) begin
        if (rst) begin
            D_O    <= '0;
            o_chan <= '0;
        end else if (!w_stall) begin
            D_O    <= w_s3;
            o_chan <= r_s2_ch;
        end
    end

endmodule : bn_multi
`default_nettype wire

// File: tb/tb_bn_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_bn_multi
// Purpose : Self-checking bench for bn_multi. Expected outputs are computed
//           by an independent 64-bit integer model at accept time, queued,
//           and compared in order as the DUT emits them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bn_multi;

    localparam int D_WL = 24;
    localparam int CH   = 16;
    localparam int CW   = 4;

    logic                   CLK;
    logic                   rst;
    logic                   relu_en;
    logic                   coef_we;
    logic [CW-1:0]          coef_addr;
    logic signed [D_WL-1:0] coef_a;
    logic signed [D_WL-1:0] coef_b;
    logic                   i_valid;
    logic                   i_first;
    logic signed [D_WL-1:0] D_IN;
    logic                   i_ready;
    logic                   o_valid;
    logic                   o_ready;
    logic signed [D_WL-1:0] D_O;
    logic [CW-1:0]          o_chan;

    bn_multi #(
        .D_WL (D_WL),
        .FL   (16),
        .CH   (CH),
        .CW   (CW)
    ) u_dut (
        .CLK       (CLK),
        .rst       (rst),
        .relu_en   (relu_en),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_a    (coef_a),
        .coef_b    (coef_b),
        .i_valid   (i_valid),
        .i_first   (i_first),
        .D_IN      (D_IN),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .D_O       (D_O),
        .o_chan    (o_chan)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [D_WL-1:0] d;
        logic [CW-1:0]   ch;
    } exp_t;

    exp_t            q[$];
    logic [D_WL-1:0] m_a [CH];
    logic [D_WL-1:0] m_b [CH];
    logic [CW-1:0]   m_cnt;

    function automatic logic [D_WL-1:0] model(input logic [D_WL-1:0] d,
                                              input logic [D_WL-1:0] a,
                                              input logic [D_WL-1:0] b,
                                              input logic relu);
        longint p, r, s;
        p = longint'($signed(d)) * longint'($signed(a));
        r = (p + 64'sd32768) >>> 16;
        s = r + longint'($signed(b));
        if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
        if (relu && s < 0) s = 0;
        return s[D_WL-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_a[i] = 24'd65536;
            m_b[i] = '0;
        end
        m_cnt = '0;
        q.delete();
    endtask

    // ---------------- output monitor ----------------
    logic            held_prev = 1'b0;
    logic [D_WL-1:0] held_d;
    logic [CW-1:0]   held_c;

    always @(negedge CLK) begin
        if (rst) begin
            held_prev = 1'b0;
        end else begin
            if (held_prev) begin
                check_eq("hold_valid", {31'd0, o_valid}, 32'd1);
                check_eq("hold_data", {8'd0, D_O}, {8'd0, held_d});
                check_eq("hold_chan", {28'd0, o_chan}, {28'd0, held_c});
            end
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    check_eq("spurious_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_eq("data", {8'd0, D_O}, {8'd0, e.d});
                    check_eq("chan", {28'd0, o_chan}, {28'd0, e.ch});
                end
            end
            held_prev = o_valid && !o_ready;
            held_d    = D_O;
            held_c    = o_chan;
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; consumes one clock; leaves inputs idle at posedge+1.
    task automatic drive(input logic v, input logic f, input logic [D_WL-1:0] d,
                         input logic we, input logic [CW-1:0] wa,
                         input logic [D_WL-1:0] wav, input logic [D_WL-1:0] wbv,
                         output logic acc);
        logic [CW-1:0] ch;
        i_valid = v; i_first = f; D_IN = d;
        coef_we = we; coef_addr = wa; coef_a = wav; coef_b = wbv;
        #1;
        acc = v && i_ready;
        if (acc) begin
            ch = f ? '0 : m_cnt;
            q.push_back('{model(d, m_a[ch], m_b[ch], relu_en), ch});
            m_cnt = (ch == CW'(CH-1)) ? '0 : ch + 1'b1;
        end
        @(posedge CLK);
        if (we) begin
            m_a[wa] = wav;
            m_b[wa] = wbv;
        end
        #1;
        i_valid = 1'b0; i_first = 1'b0; coef_we = 1'b0;
    endtask

    task automatic idle();
        logic acc;
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, acc);
    endtask

    task automatic wcoef(input logic [CW-1:0] ch, input logic [D_WL-1:0] a, input logic [D_WL-1:0] b);
        logic acc;
        drive(1'b0, 1'b0, '0, 1'b1, ch, a, b, acc);
    endtask

    task automatic send(input logic f, input logic [D_WL-1:0] d);
        logic acc;
        int   tries;
        tries = 0;
        do begin
            drive(1'b1, f, d, 1'b0, '0, '0, '0, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle();
            n++;
        end
        check_eq("drain_empty", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic            acc;
        logic [D_WL-1:0] bp_d [16];
        int              n, k, cyc;

        rst = 1'b1; relu_en = 1'b0; coef_we = 1'b0; coef_addr = '0;
        coef_a = '0; coef_b = '0; i_valid = 1'b0; i_first = 1'b0;
        D_IN = '0; o_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        do_reset();

        // reset state
        @(negedge CLK);
        check_eq("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_D_O", {8'd0, D_O}, 32'd0);
        check_eq("rst_o_chan", {28'd0, o_chan}, 32'd0);
        check_eq("rst_i_ready", {31'd0, i_ready}, 32'd1);
        @(posedge CLK);
        #1;

        // identity after reset and 3-cycle latency
        send(1'b0, 24'd163840);
        n = 0;
        while (!o_valid && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check_eq("latency", n, 32'd3);
        check_eq("ident_value", {8'd0, D_O}, 32'd163840);
        @(posedge CLK);
        #1;
        drain();

        // affine + rounding
        wcoef(4'd0, 24'd98304, 24'hFFC000);
        send(1'b1, 24'd163840);
        drain();
        wcoef(4'd0, 24'd32768, 24'd0);
        send(1'b1, 24'd1);
        send(1'b1, 24'hFFFFFF);
        drain();

        // saturation and ReLU
        wcoef(4'd0, 24'd131072, 24'd0);
        send(1'b1, 24'h7FFFFF);
        send(1'b1, 24'h800000);
        drain();
        wcoef(4'd0, 24'd65536, 24'd0);
        relu_en = 1'b1;
        send(1'b1, 24'hFF0000);
        send(1'b1, 24'd70000);
        drain();
        relu_en = 1'b0;

        // channel wrap and resync with random coefficients and data
        for (int c = 0; c < CH; c++) begin
            wcoef(CW'(c), 24'($urandom_range(0, 24'h3FFFF)), 24'($urandom));
        end
        for (int s = 0; s < 22; s++) begin
            send(s == 0 || s == 18, 24'($urandom));
        end
        drain();

        // backpressure: o_ready low for 4 cycles in a continuous stream
        for (int s = 0; s < 16; s++) bp_d[s] = 24'($urandom);
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            o_ready = !(cyc >= 6 && cyc < 10);
            drive(1'b1, 1'b0, bp_d[k], 1'b0, '0, '0, '0, acc);
            if (!o_ready) check_eq("bp_i_ready", {31'd0, acc}, 32'd0);
            if (acc) k++;
            cyc++;
        end
        o_ready = 1'b1;
        check_eq("bp_all_sent", k, 32'd16);
        drain();

        // write collision on channel 3
        wcoef(4'd3, 24'd65536, 24'd0);
        send(1'b1, 24'd1000);
        send(1'b0, 24'd2000);
        send(1'b0, 24'd3000);
        drive(1'b1, 1'b0, 24'd200000, 1'b1, 4'd3, 24'd131072, 24'd65536, acc);
        check_eq("coll_accept", {31'd0, acc}, 32'd1);
        send(1'b1, 24'd1000);
        send(1'b0, 24'd2000);
        send(1'b0, 24'd3000);
        send(1'b0, 24'd200000);
        drain();

        // reset with samples in flight
        send(1'b1, 24'd11111);
        send(1'b0, 24'd22222);
        send(1'b0, 24'd33333);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check_eq("post_rst_idle", {31'd0, o_valid}, 32'd0);
            @(posedge CLK);
            #1;
        end
        // coefficients back to identity on channels 0..3
        send(1'b0, 24'd50000);
        send(1'b0, 24'hFFF000);
        send(1'b0, 24'd7);
        send(1'b0, 24'd123456);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bn_multi
`default_nettype wire
